// File: rtl/sobel_gradient.sv
// Sobel gradient stage: two line buffers feed a 3x3 window that yields a saturated
// L1 magnitude and a 2-bit direction, with syncs delayed to match the 4-clock pipeline.
module sobel_gradient #(
    parameter int DW    = 8,
    parameter int IMG_W = 1920,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fsync,
    input  logic          hsync,
    input  logic [DW-1:0] din,
    output logic          fsync_o,
    output logic          hsync_o,
    output logic [DW-1:0] mag,
    output logic [1:0]    dir
);
    // state | meaning
    // IDLE  | no frame accepted; waits for fsync low then high, hsync ignored
    // FRAME | frame in progress; pixels counted, buffered and filtered
    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    localparam int CW = AW + 1;
    localparam int GW = DW + 3;
    localparam int PW = DW + 12;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
    localparam logic [GW-1:0] MAG_MAX = GW'((1 << DW) - 1);

    state_t        state_q, state_d;
    logic          armed_q;
    logic          hs_g_q;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d;

    logic          fs_rise, frame_act, valid, hs_fall, in_range, win_ok;
    logic [AW-1:0] rd_addr;

    // armed_q resets low, so a frame already running at reset release is skipped
    assign fs_rise   = fsync & armed_q;
    assign frame_act = fsync & ((state_q == FRAME) | armed_q);
    assign valid     = hsync & frame_act;
    assign hs_fall   = hs_g_q & ~valid;
    assign in_range  = col_q < COL_MAX;
    assign win_ok    = in_range && (col_q >= CW'(2)) && (row_q >= AW'(2));
    assign rd_addr   = in_range ? col_q[AW-1:0] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fs_rise) state_d = FRAME;
            FRAME:   if (!fsync)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (hs_fall)
            col_d = '0;
        else if (valid && in_range)
            col_d = col_q + 1'b1;
        if (state_q == IDLE && fs_rise)
            row_d = '0;
        else if (hs_fall && row_q != '1)
            row_d = row_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            hs_g_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= ~fsync;
            hs_g_q  <= valid;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    logic [DW-1:0] buf_a [IMG_W];
    logic [DW-1:0] buf_b [IMG_W];
    logic [DW-1:0] rd_a_q, rd_b_q, pix_s1_q;
    logic [AW-1:0] col_s1_q;
    logic          wr_s1_q, ok_s1_q, hs_s1_q, fs_s1_q;

    // Read-before-write on A: the old row-1 pixel is read out and moved into B
    always_ff @(posedge clk) begin
        if (valid && in_range)
            buf_a[rd_addr] <= din;
        if (wr_s1_q)
            buf_b[col_s1_q] <= rd_a_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            pix_s1_q <= '0;
            col_s1_q <= '0;
            wr_s1_q  <= 1'b0;
            ok_s1_q  <= 1'b0;
            hs_s1_q  <= 1'b0;
            fs_s1_q  <= 1'b0;
        end else begin
            rd_a_q   <= buf_a[rd_addr];
            rd_b_q   <= buf_b[rd_addr];
            pix_s1_q <= din;
            col_s1_q <= rd_addr;
            wr_s1_q  <= valid & in_range;
            ok_s1_q  <= valid & win_ok;
            hs_s1_q  <= valid;
            fs_s1_q  <= fsync;
        end
    end

    logic [DW-1:0] win_q [3][3];
    logic          ok_s2_q, hs_s2_q, fs_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win_q[i][j] <= '0;
            ok_s2_q <= 1'b0;
            hs_s2_q <= 1'b0;
            fs_s2_q <= 1'b0;
        end else begin
            if (hs_s1_q) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= rd_b_q;
                win_q[1][2] <= rd_a_q;
                win_q[2][2] <= pix_s1_q;
            end
            ok_s2_q <= ok_s1_q;
            hs_s2_q <= hs_s1_q;
            fs_s2_q <= fs_s1_q;
        end
    end

    logic [GW-1:0] gx_add, gx_sub, gy_add, gy_sub, gx, gy, ax_d, ay_d;
    logic [GW-1:0] ax_q, ay_q;
    logic          same_q, ok_s3_q, hs_s3_q, fs_s3_q;

    assign gx_add = GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]);
    assign gx_sub = GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]);
    assign gy_add = GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
    assign gy_sub = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]);
    // Two's-complement differences; magnitude never exceeds 4*(2^DW-1)
    assign gx     = gx_add - gx_sub;
    assign gy     = gy_add - gy_sub;
    assign ax_d   = gx[GW-1] ? (GW'(0) - gx) : gx;
    assign ay_d   = gy[GW-1] ? (GW'(0) - gy) : gy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ax_q    <= '0;
            ay_q    <= '0;
            same_q  <= 1'b0;
            ok_s3_q <= 1'b0;
            hs_s3_q <= 1'b0;
            fs_s3_q <= 1'b0;
        end else begin
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            same_q  <= (gx[GW-1] == gy[GW-1]);
            ok_s3_q <= ok_s2_q;
            hs_s3_q <= hs_s2_q;
            fs_s3_q <= fs_s2_q;
        end
    end

    logic [GW-1:0] sum;
    logic [PW-1:0] ay128, ax53, ax309;
    logic [DW-1:0] mag_d, mag_q;
    logic [1:0]    dir_d, dir_q;
    logic          hs_o_q, fs_o_q;

    assign sum   = ax_q + ay_q;
    assign ay128 = PW'(ay_q) << 7;
    assign ax53  = PW'(ax_q) * PW'(53);
    assign ax309 = PW'(ax_q) * PW'(309);

    // Sector thresholds: 53/128 ~ tan(22.5 deg), 309/128 ~ tan(67.5 deg)
    always_comb begin
        mag_d = '0;
        dir_d = 2'd0;
        if (ok_s3_q && hs_s3_q) begin
            mag_d = (sum > MAG_MAX) ? MAG_MAX[DW-1:0] : sum[DW-1:0];
            if (ay128 <= ax53)
                dir_d = 2'd0;
            else if (ay128 >= ax309)
                dir_d = 2'd2;
            else if (same_q)
                dir_d = 2'd1;
            else
                dir_d = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q  <= '0;
            dir_q  <= 2'd0;
            hs_o_q <= 1'b0;
            fs_o_q <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            dir_q  <= dir_d;
            hs_o_q <= hs_s3_q;
            fs_o_q <= fs_s3_q;
        end
    end

    assign mag     = mag_q;
    assign dir     = dir_q;
    assign hsync_o = hs_o_q;
    assign fsync_o = fs_o_q;

endmodule
